// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions.
// Register map and line count.
package irq_ctrl_pkg;

  localparam int N_IRQ = 8;

  typedef logic [N_IRQ-1:0] irq_vec_t;

  typedef enum logic [1:0] {
    REG_PEND = 2'd0,
    REG_MASK = 2'd1,
    REG_MODE = 2'd2,
    REG_VEC  = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl register bus.
// CPU side is master, controller is slave.
interface irq_ctrl_if;
  logic [1:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;

  modport master (
    output AD, DI, rw, cs,
    input  DO
  );

  modport slave (
    input  AD, DI, rw, cs,
    output DO
  );
endinterface

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchronizer.
// History flop gives a one-cycle rise pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// 8-line interrupt controller.
// Edge/level pending, mask, priority vector.
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  irq_ctrl_if.slave     bus,
  input  logic [7:0]    irq_in,
  output logic          irq
);

  irq_vec_t  lvl, rise;
  irq_vec_t  pend, mask, mode;
  irq_vec_t  pend_nxt, active, w1c, ack;
  logic [7:0] rd_data, do_q, vec;
  logic [2:0] idx;
  logic       any, rd, wr;
  reg_addr_e  addr;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (irq_in[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  // Bit 0 wins: scan high to low so the last hit is the lowest.
  function automatic logic [2:0] lowest(input irq_vec_t v);
    lowest = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (v[i]) lowest = 3'(i);
  endfunction

  assign addr   = reg_addr_e'(bus.AD);
  assign rd     = bus.cs & bus.rw;
  assign wr     = bus.cs & ~bus.rw;
  assign active = pend & mask;
  assign any    = |active;
  assign idx    = lowest(active);
  assign vec    = any ? {1'b1, 4'b0000, idx} : 8'h00;
  assign irq    = any;

  always_comb begin
    w1c = '0;
    ack = '0;
    if (wr && addr == REG_PEND) w1c = bus.DI;
    if (rd && addr == REG_VEC && any) ack[idx] = 1'b1;
  end

  // Rise beats clear; level lines just track s2.
  assign pend_nxt = (mode & (rise | (pend & ~(w1c | ack))))
                  | (~mode & lvl);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      addr == REG_PEND: rd_data = pend;
      addr == REG_MASK: rd_data = mask;
      addr == REG_MODE: rd_data = mode;
      addr == REG_VEC:  rd_data = vec;
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      mask <= '0;
      mode <= '0;
      do_q <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr && addr == REG_MASK) mask <= bus.DI;
      if (wr && addr == REG_MODE) mode <= bus.DI;
      if (rd) do_q <= rd_data;
    end
  end

  assign bus.DO = do_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// irq_ctrl bench: directed scenarios plus
// random traffic against a behavioural model.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       irq;

  int n_chk = 0;
  int n_err = 0;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .irq_in (irq_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Model: input sample history (0 = newest), registers, read data.
  logic [7:0] hist [3];
  logic [7:0] m_pend, m_mask, m_mode, m_do;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    m_pend = 8'h00;
    m_mask = 8'h00;
    m_mode = 8'h00;
    m_do   = 8'h00;
  endtask

  // One clock edge of the controller as described by its rules.
  task automatic model_step();
    logic [7:0] act, clr, nxt, lvl, rse, rdv;
    int first;
    lvl = hist[1];
    rse = hist[1] & ~hist[2];
    act = m_pend & m_mask;
    first = -1;
    for (int i = 0; i < 8; i++)
      if (act[i] && first < 0) first = i;
    case (bus.AD)
      2'd0: rdv = m_pend;
      2'd1: rdv = m_mask;
      2'd2: rdv = m_mode;
      default: rdv = (first >= 0) ? (8'h80 + 8'(first)) : 8'h00;
    endcase
    clr = 8'h00;
    if (bus.cs && !bus.rw && bus.AD == 2'd0) clr = bus.DI;
    if (bus.cs && bus.rw && bus.AD == 2'd3 && first >= 0)
      clr[first] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!m_mode[i])   nxt[i] = lvl[i];
      else if (rse[i])  nxt[i] = 1'b1;
      else if (clr[i])  nxt[i] = 1'b0;
      else              nxt[i] = m_pend[i];
    end
    m_pend = nxt;
    if (bus.cs && !bus.rw && bus.AD == 2'd1) m_mask = bus.DI;
    if (bus.cs && !bus.rw && bus.AD == 2'd2) m_mode = bus.DI;
    if (bus.cs && bus.rw) m_do = rdv;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", {7'b0, irq}, {7'b0, |(m_pend & m_mask)});
    chk("do", bus.DO, m_do);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
    cyc();
    bus.cs = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
    cyc();
    d = bus.DO;
    bus.cs = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs at once, release after an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_do", bus.DO, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    bus.cs = 1'b0; bus.rw = 1'b0; bus.AD = 2'd0; bus.DI = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_irq", {7'b0, irq}, 8'h00);
    chk("reset_do", bus.DO, 8'h00);
    rst = 1'b0;

    // Edge latency
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h01);
    irq_in = 8'h01;
    cyc();
    irq_in = 8'h00;
    cyc();
    chk("lat_k1", {7'b0, irq}, 8'h00);
    cyc();
    chk("lat_k2", {7'b0, irq}, 8'h01);
    rd(2'd3, v);
    chk("lat_vec", v, 8'h80);

    // Priority and auto-acknowledge
    wr(2'd1, 8'hFF);
    irq_in = 8'h24;
    cyc();
    irq_in = 8'h00;
    idle(2);
    rd(2'd3, v);
    chk("prio_v1", v, 8'h82);
    chk("prio_irq1", {7'b0, irq}, 8'h01);
    rd(2'd3, v);
    chk("prio_v2", v, 8'h85);
    chk("prio_irq2", {7'b0, irq}, 8'h00);
    rd(2'd3, v);
    chk("prio_v3", v, 8'h00);

    // Set wins over W1C
    wr(2'd0, 8'hFF);
    irq_in = 8'h08;
    cyc();
    irq_in = 8'h00;
    cyc();
    wr(2'd0, 8'h08);
    rd(2'd0, v);
    chk("setwin", v, 8'h08);
    wr(2'd0, 8'h08);
    rd(2'd0, v);
    chk("w1c", v, 8'h00);

    // Level mode
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h10);
    irq_in = 8'h10;
    idle(3);
    chk("lvl_on", {7'b0, irq}, 8'h01);
    wr(2'd0, 8'h10);
    chk("lvl_w1c", {7'b0, irq}, 8'h01);
    irq_in = 8'h00;
    cyc();
    chk("lvl_hold", {7'b0, irq}, 8'h01);
    idle(2);
    chk("lvl_off", {7'b0, irq}, 8'h00);

    // Masked line still latches
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'hFF);
    irq_in = 8'h80;
    cyc();
    irq_in = 8'h00;
    idle(2);
    chk("mask_irq0", {7'b0, irq}, 8'h00);
    rd(2'd0, v);
    chk("mask_pend", v, 8'h80);
    wr(2'd1, 8'h80);
    chk("mask_irq1", {7'b0, irq}, 8'h01);
    wr(2'd3, 8'h00);
    rd(2'd2, v);
    chk("vec_ro", v, 8'hFF);

    // Async reset with everything pending
    wr(2'd1, 8'hFF);
    irq_in = 8'hFF;
    idle(3);
    chk("all_irq", {7'b0, irq}, 8'h01);
    rd(2'd0, v);
    chk("all_pend", v, 8'hFF);
    async_reset();
    rd(2'd0, v);
    chk("post_rst_pend", v, 8'h00);
    idle(3);
    wr(2'd2, 8'hFF);
    wr(2'd0, 8'hFF);
    idle(3);
    rd(2'd0, v);
    chk("held_no_repend", v, 8'h00);
    irq_in = 8'h00;
    idle(4);
    irq_in = 8'hFF;
    idle(3);
    rd(2'd0, v);
    chk("fresh_repend", v, 8'hFF);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
      bus.cs = ($urandom_range(0, 1) == 1);
      bus.rw = ($urandom_range(0, 1) == 1);
      bus.AD = 2'($urandom);
      bus.DI = 8'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end
    bus.cs = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, bus and all state
- rst  in  1  asynchronous active-high reset
- AD  in  2  register select
- DI  in  8  write data
- DO  out  8  registered read data
- rw  in  1  1 = read, 0 = write
- cs  in  1  register access strobe
- irq_in  in  8  interrupt request lines, active-high; bit 0 is the timer/IO block irq
- irq  out  1  combined request to the CPU, active-high
REQ-003 The register map SHALL be:
- $0 PEND  R/W1C  latched pending bits
- $1 MASK  RW  enable per line
- $2 MODE  RW  1 = edge-triggered, 0 = level
- $3 VEC  R-  bit7 = ANY, bits 6:3 = 0, bits 2:0 = IDX

Function
REQ-004 Each irq_in bit SHALL pass through a two-flop synchronizer (s1, s2) plus a history flop (s3).
REQ-005 Edge mode: pending[i] SHALL set on the edge where s2[i] & ~s3[i]. It SHALL hold until cleared by W1C or by VEC auto-acknowledge.
REQ-006 Level mode: pending[i] SHALL equal s2[i], registered each cycle; W1C and auto-acknowledge SHALL have no effect on it.
REQ-007 irq SHALL equal OR(pending & MASK), driven combinationally from registers.
REQ-008 Latency (edge mode): irq_in[i] high before edge k -> s2 high after edge k+1 -> pending set at edge k+2 -> irq high after edge k+2. Level mode has the same latency.
REQ-009 The active set SHALL be pending & MASK.
- IDX = lowest-numbered active bit (bit 0 is highest priority).
- ANY = 1 if any bit is active; if none, VEC reads $00.
REQ-010 Reads: on an edge with cs=1 and rw=1, DO SHALL load the selected register. DO SHALL hold its value at all other times.
REQ-011 A read of VEC with ANY=1 SHALL clear pending[IDX] on the same edge if that line is in edge mode.
REQ-012 A write to PEND SHALL clear each pending bit whose DI bit is 1 (edge-mode lines only).
REQ-013 Simultaneous set and clear (W1C or auto-acknowledge) of the same bit on the same edge: set SHALL win.
REQ-014 Writes to MASK and MODE SHALL take effect on that edge; irq SHALL update after the same edge.
REQ-015 MODE change from level to edge SHALL keep the current pending value; MODE change from edge to level SHALL overwrite pending with s2 on the next edge.
REQ-016 Masked lines SHALL still latch pending; unmasking a pending line SHALL assert irq after the write edge.
REQ-017 Writes to $3 SHALL be ignored.

Reset
REQ-018 On rst, the following SHALL clear immediately regardless of clk: s1, s2, s3, pending, MASK, MODE, and DO to $00; irq therefore reads 0.
REQ-019 Reset mid-operation SHALL discard all pending requests. An input still high after reset SHALL re-pend via REQ-008, in edge mode only on a fresh rising edge.

Structure
REQ-020 A shared package SHALL hold the register address constants (PEND, MASK, MODE, VEC) and the line count constant (8).
REQ-021 The per-line synchronizer and edge detector SHALL be a sub-module irq_sync_edge, instantiated 8 times. Its outputs are level (s2) and rise (s2 & ~s3).
REQ-022 The priority encoder SHALL be written inline in irq_ctrl as a combinational function.

Verification
REQ-023 Edge latency: MODE=$FF, MASK=$01; pulse irq_in[0] for 1 cycle before edge k -> irq=1 after edge k+2; VEC reads $80.
REQ-024 Priority and auto-acknowledge: MODE=$FF, MASK=$FF; rise on irq_in[5] and irq_in[2] together -> VEC reads $82, then $85, then $00; irq falls after the second VEC read edge.
REQ-025 Set wins: MODE=$FF; write PEND=$08 on the same edge that line 3's rise is detected -> PEND reads $08 afterwards.
REQ-026 Level mode: MODE=$00, MASK=$10; hold irq_in[4] high -> irq stays 1; W1C $10 -> no change; drop input -> irq=0 two edges later.
REQ-027 Masking: MODE=$FF, MASK=$00; pulse irq_in[7] -> irq=0 and PEND reads $80; write MASK=$80 -> irq=1 after the write edge.
REQ-028 Async reset: with pending=$FF and irq=1, assert rst between edges -> irq, DO and PEND are 0 immediately; with irq_in held high in edge mode, nothing re-pends until the input falls and rises again.
